dac_sample_sched: RTL and testbench

- Paces 10-bit sample codes into the SoC's DAC at a programmable rate.
- The CPU (or a DMA-style master) pushes samples through a valid/ready port into a small FIFO.
- The block pops one sample per rate tick, drives the registered DAC code and flags underruns.
- It sits between the core's memory-mapped write path and the DAC D input, in the PLL-derived CLK domain.

---
 rtl/dac_sched_pkg.sv | 13 +
 rtl/dac_sample_fifo.sv | 77 +++++++
 rtl/dac_sample_sched.sv | 122 ++++++++++++
 tb/tb_dac_sample_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// Shared types and defaults for the DAC sample scheduler and its DAC wrapper.
package dac_sched_pkg;

    localparam int unsigned DATA_W_DEF   = 10;
    localparam int unsigned MIDSCALE_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with push/pop/flush and a separate occupancy count.
module dac_sample_fifo
    import dac_sched_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Flush wins over any same-cycle push or pop; full refuses a push even when popping.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointer and count next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; only read behind a valid count, so no reset needed.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Paces FIFO'd sample codes into the DAC at a programmable tick rate.
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned PRIME_LVL = 4,
    parameter int unsigned MIDSCALE  = MIDSCALE_DEF
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [DIV_W-1:0]         div,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        dac_code,
    output logic                     dac_update,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    input  logic                     clr_underrun
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    sched_state_e      state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dac_code_q, dac_code_d;
    logic              dac_update_q, dac_update_d;
    logic              underrun_q, underrun_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  level;
    logic              push;
    logic              pop;
    logic              tick;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !flush;
    assign tick     = (state_q == ST_RUN) && (cnt_q >= div);
    assign pop      = tick && !fifo_empty && !flush;

    dac_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_data),
        .rd_data (fifo_head),
        .count   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM next-state, rate divider and DAC output register next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        dac_code_d   = dac_code_q;
        dac_update_d = 1'b0;
        underrun_d   = underrun_q;

        if (clr_underrun) underrun_d = 1'b0;
        if (tick && fifo_empty && !flush) underrun_d = 1'b1;

        if (flush) begin
            state_d    = enable ? ST_PRIME : ST_IDLE;
            dac_code_d = DATA_W'(MIDSCALE);
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = enable ? ST_PRIME : ST_IDLE;
                ST_PRIME: begin
                    if (!enable)                         state_d = ST_IDLE;
                    else if (level >= LVL_W'(PRIME_LVL)) state_d = ST_RUN;
                end
                ST_RUN:   state_d = enable ? ST_RUN : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase

            if (pop) begin
                dac_code_d   = fifo_head;
                dac_update_d = 1'b1;
            end

            // Divider only free-runs while staying in RUN; it restarts from 0 on entry.
            if (state_q == ST_RUN && state_d == ST_RUN) begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            end
        end
    end

    // State, divider and output registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dac_code_q   <= DATA_W'(MIDSCALE);
            dac_update_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dac_code_q   <= dac_code_d;
            dac_update_q <= dac_update_d;
            underrun_q   <= underrun_d;
        end
    end

    assign dac_code   = dac_code_q;
    assign dac_update = dac_update_q;
    assign underrun   = underrun_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Self-checking bench for dac_sample_sched: directed scenarios plus randomized traffic.
module tb_dac_sample_sched;

    localparam int DEPTH     = 8;
    localparam int PRIME_LVL = 4;
    localparam int MID       = 512;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        flush;
    logic [15:0] div;
    logic        in_valid;
    logic [9:0]  in_data;
    logic        in_ready;
    logic [9:0]  dac_code;
    logic        dac_update;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        clr_underrun;

    always #5 CLK = ~CLK;

    dac_sample_sched dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .enable       (enable),
        .flush        (flush),
        .div          (div),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .dac_code     (dac_code),
        .dac_update   (dac_update),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    int checks = 0;
    int errors = 0;
    int cycnum = 0;

    // Behavioural model: a queue of samples plus playback mode (0 idle, 1 priming, 2 playing).
    int q[$];
    int m_mode;
    int m_cnt;
    int m_code;
    int m_upd;
    int m_und;

    int upd_cyc[$];
    int upd_code[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_mode = 0;
        m_cnt  = 0;
        m_code = MID;
        m_upd  = 0;
        m_und  = 0;
    endfunction

    function automatic void model_step();
        int sz;
        int nmode;
        bit ready;
        bit tk;
        sz    = q.size();
        ready = (sz < DEPTH);
        tk    = (m_mode == 2) && (m_cnt >= int'(div));
        m_upd = 0;
        if (clr_underrun) m_und = 0;
        if (flush) begin
            q.delete();
            m_code = MID;
            m_mode = enable ? 1 : 0;
            m_cnt  = 0;
            return;
        end
        if (tk) begin
            if (sz > 0) begin
                m_code = q.pop_front();
                m_upd  = 1;
            end else begin
                m_und = 1;
            end
        end
        if (in_valid && ready) q.push_back(int'(in_data));
        case (m_mode)
            0:       nmode = enable ? 1 : 0;
            1:       nmode = !enable ? 0 : ((sz >= PRIME_LVL) ? 2 : 1);
            default: nmode = enable ? 2 : 0;
        endcase
        m_cnt  = (m_mode == 2 && nmode == 2) ? (tk ? 0 : m_cnt + 1) : 0;
        m_mode = nmode;
    endfunction

    // One clock cycle: compare against the model mid-cycle, then advance the model.
    task automatic cyc();
        @(negedge CLK);
        cycnum++;
        chk("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("dac_code",   32'(dac_code),   32'(m_code));
        chk("dac_update", 32'(dac_update), 32'(m_upd));
        chk("underrun",   32'(underrun),   32'(m_und));
        if (dac_update === 1'b1) begin
            upd_cyc.push_back(cycnum);
            upd_code.push_back(int'(dac_code));
        end
        if (!reset_n) model_reset();
        else          model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_one(input int v);
        in_valid = 1'b1;
        in_data  = 10'(v);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        int found;
        int c0;
        int n777;

        reset_n      = 1'b0;
        enable       = 1'b0;
        flush        = 1'b0;
        div          = 16'd0;
        in_valid     = 1'b0;
        in_data      = 10'd0;
        clr_underrun = 1'b0;
        model_reset();
        repeat (3) cyc();

        // Reset values.
        chk("rst_dac_code",   32'(dac_code),   32'(MID));
        chk("rst_dac_update", 32'(dac_update), 32'd0);
        chk("rst_underrun",   32'(underrun),   32'd0);
        chk("rst_level",      32'(fifo_level), 32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        reset_n = 1'b1;
        cyc();

        // Basic pacing: four samples at div=3, then underrun once drained.
        enable = 1'b1;
        div    = 16'd3;
        upd_cyc.delete();
        upd_code.delete();
        for (int i = 1; i <= 4; i++) push_one(i * 100);
        repeat (24) cyc();
        chk("t1_n_updates", 32'(upd_code.size()), 32'd4);
        for (int i = 0; i < upd_code.size() && i < 4; i++) begin
            chk("t1_code", 32'(upd_code[i]), 32'((i + 1) * 100));
            if (i > 0) chk("t1_spacing", 32'(upd_cyc[i] - upd_cyc[i-1]), 32'd4);
        end
        chk("t1_underrun", 32'(underrun), 32'd1);
        chk("t1_hold",     32'(dac_code), 32'd400);
        enable = 1'b0;
        cyc();
        clr_underrun = 1'b1;
        cyc();
        clr_underrun = 1'b0;
        chk("t1_clr", 32'(underrun), 32'd0);

        // div=0: back-to-back pops then an underrun on the fifth tick.
        div = 16'd0;
        for (int i = 1; i <= 4; i++) push_one(i * 100);
        upd_cyc.delete();
        upd_code.delete();
        enable = 1'b1;
        repeat (8) cyc();
        chk("t2_n_updates", 32'(upd_code.size()), 32'd4);
        for (int i = 1; i < upd_cyc.size(); i++)
            chk("t2_consecutive", 32'(upd_cyc[i] - upd_cyc[0]), 32'(i));
        chk("t2_underrun", 32'(underrun), 32'd1);
        chk("t2_hold",     32'(dac_code), 32'd400);
        enable = 1'b0;
        cyc();
        clr_underrun = 1'b1;
        cyc();
        clr_underrun = 1'b0;
        chk("t2_clr", 32'(underrun), 32'd0);

        // Fill to full while idle; refused pushes, including in the pop cycle.
        for (int i = 0; i < DEPTH; i++) push_one(int'($urandom_range(0, 1023)));
        chk("t3_level_full", 32'(fifo_level), 32'd8);
        chk("t3_not_ready",  32'(in_ready),   32'd0);
        in_valid = 1'b1;
        in_data  = 10'd999;
        cyc();
        chk("t3_refused", 32'(fifo_level), 32'd8);
        enable = 1'b1;
        div    = 16'd0;
        cyc();
        cyc();
        chk("t3_pop_cycle_not_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("t3_after_pop_ready", 32'(in_ready),   32'd1);
        chk("t3_after_pop_level", 32'(fifo_level), 32'd7);
        cyc();
        chk("t3_push_pop_level", 32'(fifo_level), 32'd7);
        in_valid = 1'b0;
        repeat (12) cyc();

        // Flush mid-run with a simultaneous push.
        div = 16'd1;
        for (int i = 0; i < 6; i++) push_one(int'($urandom_range(0, 700)));
        repeat (3) cyc();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'd777;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_level",    32'(fifo_level), 32'd0);
        chk("t4_midscale", 32'(dac_code),   32'(MID));
        chk("t4_ready",    32'(in_ready),   32'd1);
        upd_cyc.delete();
        upd_code.delete();
        repeat (5) cyc();
        chk("t4_primed_no_play", 32'(upd_code.size()), 32'd0);
        for (int i = 0; i < 4; i++) push_one(int'($urandom_range(0, 700)));
        repeat (20) cyc();
        n777 = 0;
        foreach (upd_code[i]) if (upd_code[i] == 777) n777++;
        chk("t4_dropped_absent", 32'(n777), 32'd0);
        chk("t4_played_after_prime", 32'(upd_code.size()), 32'd4);

        // Divider shrink below the running count ticks straight away.
        enable = 1'b0;
        cyc();
        for (int i = 0; i < DEPTH; i++) push_one(int'($urandom_range(0, 1023)));
        enable = 1'b1;
        div    = 16'd9;
        found  = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (m_mode == 2 && m_cnt == 7) found = 1;
            else cyc();
        end
        chk("t5_reached_cnt7", 32'(found), 32'd1);
        upd_cyc.delete();
        upd_code.delete();
        div = 16'd2;
        c0  = cycnum + 1;
        repeat (8) cyc();
        chk("t5_n_updates", 32'(upd_cyc.size() >= 2), 32'd1);
        if (upd_cyc.size() >= 2) begin
            chk("t5_first_tick", 32'(upd_cyc[0]), 32'(c0 + 1));
            chk("t5_period",     32'(upd_cyc[1] - upd_cyc[0]), 32'd3);
        end

        // Asynchronous reset between edges while running with underrun set.
        div = 16'd0;
        repeat (12) cyc();
        chk("t6_pre_underrun", 32'(underrun), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_code",     32'(dac_code),   32'(MID));
        chk("t6_async_underrun", 32'(underrun),   32'd0);
        chk("t6_async_ready",    32'(in_ready),   32'd1);
        chk("t6_async_level",    32'(fifo_level), 32'd0);
        chk("t6_async_update",   32'(dac_update), 32'd0);
        model_reset();
        cyc();
        reset_n = 1'b1;
        cyc();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 2) != 0);
            in_data      = 10'($urandom_range(0, 1023));
            enable       = ($urandom_range(0, 15) != 0);
            flush        = ($urandom_range(0, 40) == 0);
            clr_underrun = ($urandom_range(0, 20) == 0);
            if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 4));
            cyc();
        end
        in_valid     = 1'b0;
        flush        = 1'b0;
        clr_underrun = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
